fetch_queue_unit: RTL and testbench



---
 rtl/fetch_queue_unit_if.sv | 39 +++
 rtl/fetch_queue_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bus bundle: start/redirect control, memory request/response and decode delivery.
// Pure wiring, no latency of its own.
// Handshakes: mem_read/mem_ready for requests, mem_valid for responses, inst_valid/inst_ready to decode.
interface fetch_queue_unit_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20
);
   // control from the pipeline
   logic                    start;
   logic [ADDRESS_BITS-1:0] program_address;
   logic                    redirect;
   logic [ADDRESS_BITS-1:0] redirect_target;
   // instruction memory port
   logic                    mem_read;
   logic [ADDRESS_BITS-1:0] mem_address;
   logic                    mem_ready;
   logic                    mem_valid;
   logic [DATA_WIDTH-1:0]   mem_data;
   // decode side
   logic                    inst_valid;
   logic                    inst_ready;
   logic [DATA_WIDTH-1:0]   instruction;
   logic [ADDRESS_BITS-1:0] inst_PC;
   logic                    busy;

   // the fetch unit drives requests and decode outputs
   modport master (
      input  start, program_address, redirect, redirect_target,
      input  mem_ready, mem_valid, mem_data, inst_ready,
      output mem_read, mem_address, inst_valid, instruction, inst_PC, busy
   );

   // the environment (pipeline, memory, decode)
   modport slave (
      output start, program_address, redirect, redirect_target,
      output mem_ready, mem_valid, mem_data, inst_ready,
      input  mem_read, mem_address, inst_valid, instruction, inst_PC, busy
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// Sequential-PC instruction fetch with pipelined memory reads and a response queue to decode.
// Latency: response visible one cycle after mem_valid (same cycle into an empty queue with FETCH_BYPASS_EN).
// Backpressure: credits (queue count + outstanding) throttle mem_read; inst_ready low holds the head.
module fetch_queue_unit #(
   parameter int                      DATA_WIDTH      = 32,
   parameter int                      ADDRESS_BITS    = 20,
   parameter int                      QUEUE_DEPTH     = 4,
   parameter int                      MAX_OUTSTANDING = 2,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC        = '0
) (
   input logic                clock,
   input logic                reset,
   fetch_queue_unit_if.master bus
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int CU_W  = CNT_W + 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state;
   logic [ADDRESS_BITS-1:0] fetch_pc;
   logic [ADDRESS_BITS-1:0] resp_pc;
   logic [CNT_W-1:0]        count;
   logic [OUT_W-1:0]        outstanding;
   logic [OUT_W-1:0]        drop_count;
   logic [PTR_W-1:0]        head;
   logic [PTR_W-1:0]        tail;
   logic [DATA_WIDTH-1:0]   q_data [QUEUE_DEPTH];
   logic [ADDRESS_BITS-1:0] q_pc   [QUEUE_DEPTH];

   logic                    flush;
   logic [ADDRESS_BITS-1:0] target;
   logic [CU_W-1:0]         credit_used;
   logic                    issue;
   logic                    accept;
   logic                    consume;
   logic                    keep;
   logic                    bypass;
   logic                    push;
   logic                    pop;

   // start has priority over redirect; targets are always word aligned
   assign flush  = bus.start | bus.redirect;
   assign target = (bus.start ? bus.program_address : bus.redirect_target) & ALIGN_MASK;

   // a request may go out only if its response is guaranteed a queue slot
   always_comb begin
      credit_used = {1'b0, count} + CU_W'(outstanding);
      issue       = (state == RUN)
                 && (credit_used < CU_W'(QUEUE_DEPTH))
                 && (outstanding < OUT_W'(MAX_OUTSTANDING))
                 && !flush;
   end

   assign accept  = issue && bus.mem_ready;
   // responses with nothing in flight are spurious and ignored
   assign consume = bus.mem_valid && (outstanding != '0);
   // a response survives only if it is not stale and not racing a flush
   assign keep    = consume && (drop_count == '0) && !flush;

`ifdef FETCH_BYPASS_EN
   assign bypass = keep && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   // a bypassed response taken by decode never occupies a slot
   assign push = keep && !(bypass && bus.inst_ready);
   // the queue is discarded on flush, so a pop that cycle means nothing
   assign pop  = (count != '0) && bus.inst_ready && !flush;

   assign bus.mem_read    = issue;
   assign bus.mem_address = fetch_pc;
   assign bus.busy        = (state == RUN);

   // decode sees the queue head, or the live response when bypassing an empty queue
   always_comb begin
      bus.inst_valid  = 1'b0;
      bus.instruction = '0;
      bus.inst_PC     = '0;
      if (count != '0) begin
         bus.inst_valid  = 1'b1;
         bus.instruction = q_data[head];
         bus.inst_PC     = q_pc[head];
      end else if (bypass) begin
         bus.inst_valid  = 1'b1;
         bus.instruction = bus.mem_data;
         bus.inst_PC     = resp_pc;
      end
   end

   // queue storage; contents are don't-care until count marks them valid
   always_ff @(posedge clock) begin
      if (push) begin
         q_data[tail] <= bus.mem_data;
         q_pc[tail]   <= resp_pc;
      end
   end

   // run/idle FSM, PCs, credit counters and queue pointers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop_count  <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         // in-flight tracking continues across flushes so stale responses can be counted off
         outstanding <= outstanding + OUT_W'(accept) - OUT_W'(consume);
         if (flush) begin
            if (bus.start) begin
               state <= RUN;
            end
            fetch_pc   <= target;
            resp_pc    <= target;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            // everything still in flight after this cycle belongs to the old stream
            drop_count <= outstanding - OUT_W'(consume);
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + ADDRESS_BITS'(4);
            end
            if (keep) begin
               resp_pc <= resp_pc + ADDRESS_BITS'(4);
            end
            if (consume && (drop_count != '0)) begin
               drop_count <= drop_count - OUT_W'(1);
            end
            if (push) begin
               tail <= tail + PTR_W'(1);
            end
            if (pop) begin
               head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus randomized traffic
// against a queue-based model of the fetch stream (in-flight requests tagged stale on flush).
module tb_fetch_queue_unit;
   localparam int DW = 32;
   localparam int AB = 20;
   localparam int QD = 4;
   localparam int MO = 2;
   localparam logic [AB-1:0] ALIGN = ~AB'(3);

   logic clock = 1'b0;
   logic reset = 1'b1;

   fetch_queue_unit_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus ();

   fetch_queue_unit #(
      .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .QUEUE_DEPTH(QD),
      .MAX_OUTSTANDING(MO), .RESET_PC('0)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   // reference model state
   bit              running;
   logic [AB-1:0]   m_fetch_pc;
   logic [AB-1:0]   infl_addr [$];
   bit              infl_stale [$];
   logic [DW-1:0]   q_dat [$];
   logic [AB-1:0]   q_pc [$];
   // observations of what decode actually received
   logic [AB-1:0]   got_pc [$];
   logic [DW-1:0]   got_dat [$];

   int              n_checks = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   int              n_acc    = 0;
   logic [DW-1:0]   seed;

   function automatic logic [DW-1:0] mdata(input logic [AB-1:0] a);
      if (a == AB'(32'h40)) return 32'hDEADBEEF;
      return {a[11:0], a} ^ seed;
   endfunction

   task automatic model_reset();
      running    = 1'b0;
      m_fetch_pc = '0;
      infl_addr.delete();
      infl_stale.delete();
      q_dat.delete();
      q_pc.delete();
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset          = 1'b0;
      bus.start      = 1'b0;
      bus.redirect   = 1'b0;
      bus.mem_valid  = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.inst_ready = 1'b0;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   // one clock: drive inputs, check every output against the model, advance the model
   task automatic step(input logic st, input logic [AB-1:0] pa, input logic rd, input logic [AB-1:0] rt,
                       input logic irdy, input logic mrdy, input logic mvld);
      logic          flush, exp_read, live, byp, exp_iv;
      logic [AB-1:0] tgt, exp_pc, ra;
      logic [DW-1:0] rdat, exp_ins;
      @(negedge clock);
      cyc++;
      flush = st | rd;
      tgt   = (st ? pa : rt) & ALIGN;
      rdat  = (infl_addr.size() > 0) ? mdata(infl_addr[0]) : DW'($urandom);
      bus.start           = st;
      bus.program_address = pa;
      bus.redirect        = rd;
      bus.redirect_target = rt;
      bus.inst_ready      = irdy;
      bus.mem_ready       = mrdy;
      bus.mem_valid       = mvld;
      bus.mem_data        = rdat;
      #1;
      exp_read = running && (q_dat.size() + infl_addr.size() < QD) && (infl_addr.size() < MO) && !flush;
      live     = mvld && (infl_addr.size() > 0) && !infl_stale[0] && !flush;
`ifdef FETCH_BYPASS_EN
      byp = live && (q_dat.size() == 0);
`else
      byp = 1'b0;
`endif
      exp_iv  = (q_dat.size() != 0) || byp;
      exp_ins = (q_dat.size() != 0) ? q_dat[0] : (byp ? rdat : '0);
      exp_pc  = (q_pc.size() != 0) ? q_pc[0] : (byp ? infl_addr[0] : '0);

      n_checks++;
      if (bus.mem_read !== exp_read) begin
         n_fail++; $display("FAIL mem_read cyc=%0d got=%b expected=%b", cyc, bus.mem_read, exp_read);
      end
      if (exp_read) begin
         n_checks++;
         if (bus.mem_address !== m_fetch_pc) begin
            n_fail++; $display("FAIL mem_address cyc=%0d got=%h expected=%h", cyc, bus.mem_address, m_fetch_pc);
         end
      end
      n_checks++;
      if (bus.inst_valid !== exp_iv) begin
         n_fail++; $display("FAIL inst_valid cyc=%0d got=%b expected=%b", cyc, bus.inst_valid, exp_iv);
      end
      n_checks++;
      if (bus.instruction !== exp_ins) begin
         n_fail++; $display("FAIL instruction cyc=%0d got=%h expected=%h", cyc, bus.instruction, exp_ins);
      end
      n_checks++;
      if (bus.inst_PC !== exp_pc) begin
         n_fail++; $display("FAIL inst_PC cyc=%0d got=%h expected=%h", cyc, bus.inst_PC, exp_pc);
      end
      n_checks++;
      if (bus.busy !== running) begin
         n_fail++; $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, bus.busy, running);
      end

      if (bus.inst_valid === 1'b1 && irdy && !flush) begin
         got_pc.push_back(bus.inst_PC);
         got_dat.push_back(bus.instruction);
      end
      if (bus.mem_read === 1'b1 && mrdy) n_acc++;

      // model update for the coming clock edge
      if (!flush && (q_dat.size() != 0) && irdy) begin
         void'(q_dat.pop_front());
         void'(q_pc.pop_front());
      end
      if (mvld && (infl_addr.size() > 0)) begin
         ra = infl_addr.pop_front();
         void'(infl_stale.pop_front());
         if (live && !(byp && irdy)) begin
            q_dat.push_back(rdat);
            q_pc.push_back(ra);
         end
      end
      if (flush) begin
         q_dat.delete();
         q_pc.delete();
         foreach (infl_stale[i]) infl_stale[i] = 1'b1;
         m_fetch_pc = tgt;
         if (st) running = 1'b1;
      end else if (exp_read && mrdy) begin
         infl_addr.push_back(m_fetch_pc);
         infl_stale.push_back(1'b0);
         m_fetch_pc = m_fetch_pc + AB'(4);
      end
   endtask

   task automatic test_reset();
      bus.start = 0; bus.program_address = '0; bus.redirect = 0; bus.redirect_target = '0;
      bus.mem_ready = 0; bus.mem_valid = 0; bus.mem_data = '0; bus.inst_ready = 0;
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got=%b expected=0", bus.mem_read); end
      n_checks++;
      if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got=%b expected=0", bus.inst_valid); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b expected=0", bus.busy); end
      n_checks++;
      if (bus.inst_PC !== '0) begin n_fail++; $display("FAIL reset_inst_PC got=%h expected=0", bus.inst_PC); end
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (3) step(0, '0, 0, '0, 1, 1, 1);
   endtask

   task automatic test_stream();
      pulse_reset();
      step(1, AB'(32'h100), 0, '0, 1, 1, 1);
      got_pc.delete(); got_dat.delete();
      repeat (12) step(0, '0, 0, '0, 1, 1, 1);
      n_checks++;
      if (got_pc.size() < 3) begin n_fail++; $display("FAIL stream_count got=%0d expected>=3", got_pc.size()); end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (got_pc[i] !== AB'(32'h100 + 4 * i)) begin
            n_fail++; $display("FAIL stream_pc[%0d] got=%h expected=%h", i, got_pc[i], AB'(32'h100 + 4 * i));
         end
         n_checks++;
         if (got_dat[i] !== mdata(AB'(32'h100 + 4 * i))) begin
            n_fail++; $display("FAIL stream_data[%0d] got=%h expected=%h", i, got_dat[i], mdata(AB'(32'h100 + 4 * i)));
         end
      end
   endtask

   task automatic test_backpressure();
      pulse_reset();
      n_acc = 0;
      step(1, AB'(32'h800), 0, '0, 0, 1, 1);
      repeat (12) step(0, '0, 0, '0, 0, 1, 1);
      n_checks++;
      if (n_acc !== 4) begin n_fail++; $display("FAIL bp_requests got=%0d expected=4", n_acc); end
      got_pc.delete(); got_dat.delete();
      repeat (10) step(0, '0, 0, '0, 1, 1, 1);
      n_checks++;
      if (got_pc.size() < 4) begin n_fail++; $display("FAIL bp_delivered got=%0d expected>=4", got_pc.size()); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got_pc[i] !== AB'(32'h800 + 4 * i)) begin
            n_fail++; $display("FAIL bp_pc[%0d] got=%h expected=%h", i, got_pc[i], AB'(32'h800 + 4 * i));
         end
      end
   endtask

   task automatic test_redirect();
      int guard;
      pulse_reset();
      step(1, AB'(32'h500), 0, '0, 0, 1, 1);
      guard = 0;
      while (!(q_dat.size() == 2 && infl_addr.size() == 2) && guard < 20) begin
         step(0, '0, 0, '0, 0, 1, q_dat.size() < 2);
         guard++;
      end
      n_checks++;
      if (guard >= 20) begin n_fail++; $display("FAIL redir_setup got=timeout expected=count2_out2"); end
      step(0, '0, 1, AB'(32'h2002), 0, 1, 0);
      got_pc.delete(); got_dat.delete();
      step(0, '0, 0, '0, 1, 1, 1);
      n_checks++;
      if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flushed got=%b expected=0", bus.inst_valid); end
      repeat (12) step(0, '0, 0, '0, 1, 1, 1);
      n_checks++;
      if (got_pc.size() == 0 || got_pc[0] !== AB'(32'h2000)) begin
         n_fail++; $display("FAIL redir_first_pc got=%h expected=02000", (got_pc.size() != 0) ? got_pc[0] : AB'(0));
      end
   endtask

   task automatic test_start_redirect();
      pulse_reset();
      step(1, AB'(32'h600), 0, '0, 1, 1, 0);
      repeat (2) step(0, '0, 0, '0, 1, 1, 0);
      got_pc.delete(); got_dat.delete();
      step(1, AB'(32'h400), 1, AB'(32'h300), 1, 1, 1);
      step(0, '0, 0, '0, 1, 1, 1);
      n_checks++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== AB'(32'h400)) begin
         n_fail++; $display("FAIL both_resume got=%b/%h expected=1/00400", bus.mem_read, bus.mem_address);
      end
      repeat (10) step(0, '0, 0, '0, 1, 1, 1);
      n_checks++;
      if (got_pc.size() == 0 || got_pc[0] !== AB'(32'h400)) begin
         n_fail++; $display("FAIL both_first_pc got=%h expected=00400", (got_pc.size() != 0) ? got_pc[0] : AB'(0));
      end
   endtask

   task automatic test_latency();
      pulse_reset();
      step(1, AB'(32'h40), 0, '0, 1, 0, 0);
      step(0, '0, 0, '0, 1, 1, 0);   // request 0x40 accepted
      step(0, '0, 0, '0, 1, 0, 1);   // response arrives
`ifdef FETCH_BYPASS_EN
      n_checks++;
      if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'hDEADBEEF || bus.inst_PC !== AB'(32'h40)) begin
         n_fail++; $display("FAIL lat_bypass got=%b/%h/%h expected=1/deadbeef/00040", bus.inst_valid, bus.instruction, bus.inst_PC);
      end
      step(0, '0, 0, '0, 1, 0, 0);
      n_checks++;
      if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL lat_count0 got=%b expected=0", bus.inst_valid); end
`else
      n_checks++;
      if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL lat_same_cycle got=%b expected=0", bus.inst_valid); end
      step(0, '0, 0, '0, 1, 0, 0);
      n_checks++;
      if (bus.inst_valid !== 1'b1 || bus.instruction !== 32'hDEADBEEF || bus.inst_PC !== AB'(32'h40)) begin
         n_fail++; $display("FAIL lat_next_cycle got=%b/%h/%h expected=1/deadbeef/00040", bus.inst_valid, bus.instruction, bus.inst_PC);
      end
`endif
   endtask

   task automatic test_reset_midrun();
      int guard;
      pulse_reset();
      step(1, AB'(32'hA00), 0, '0, 0, 1, 1);
      guard = 0;
      while (q_dat.size() != 3 && guard < 20) begin
         step(0, '0, 0, '0, 0, 1, 1);
         guard++;
      end
      n_checks++;
      if (guard >= 20) begin n_fail++; $display("FAIL mid_setup got=timeout expected=count3"); end
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_read !== 1'b0 || bus.inst_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got=%b%b%b expected=000", bus.mem_read, bus.inst_valid, bus.busy);
      end
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      n_acc = 0;
      repeat (5) step(0, '0, 0, '0, 1, 1, 0);
      n_checks++;
      if (n_acc !== 0) begin n_fail++; $display("FAIL mid_no_requests got=%0d expected=0", n_acc); end
   endtask

   task automatic test_random();
      logic          st, rd;
      logic [AB-1:0] pa, rt;
      pulse_reset();
      step(0, '0, 1, AB'($urandom), 1, 1, 0);   // redirect while idle: no activity
      step(1, AB'($urandom), 0, '0, 1, 1, 1);
      for (int i = 0; i < 400; i++) begin
         st = ($urandom_range(0, 39) == 0);
         rd = ($urandom_range(0, 19) == 0);
         pa = AB'($urandom);
         rt = AB'($urandom);
         step(st, pa, rd, rt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end
   endtask

   initial begin
      seed = DW'($urandom);
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_start_redirect();
      test_latency();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=completion");
      $fatal(1, "watchdog");
   end
endmodule
